// File: rtl/mem_bus_slave.sv
// Word-addressed on-chip memory slave on the CPU's shared tri-state data bus.
// Serial FSM: address decode, programmable wait states, single-cycle ready/fault pulses.
module mem_bus_slave #(
    parameter int          DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [31:0] bus,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    output logic        ready,
    output logic        fault
);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, HOLD, ERR} state_t;
    typedef enum logic [1:0] {HOLD_RD, HOLD_WR, HOLD_ERR} hold_t;

    state_t        state, state_next;
    hold_t         kind, kind_next;
    logic [CW-1:0] cnt, cnt_next;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] addr_idx;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          hit;
    logic          accept_rd;
    logic          accept_wr;
    logic          commit;
    logic          drive;

    // Base is aligned to the window size, so a hit is an upper-bit match plus word alignment.
    assign addr_idx  = address[AW+1:2];
    assign hit       = (address[31:AW+2] == BASE_ADDR[31:AW+2]) && (address[1:0] == 2'b00);
    assign accept_rd = (state == IDLE) && read && !write && hit;
    assign accept_wr = (state == IDLE) && write && !read && hit;
    assign commit    = (state == WR_WAIT) && (cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            kind  <= HOLD_RD;
            cnt   <= '0;
        end else begin
            state <= state_next;
            kind  <= kind_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        kind_next  = kind;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if ((read && write) || ((read || write) && !hit)) begin
                    state_next = ERR;
                end else if (read) begin
                    cnt_next   = CW'(READ_LATENCY - 1);
                    state_next = (READ_LATENCY == 1) ? RD_DRIVE : RD_WAIT;
                end else if (write) begin
                    cnt_next   = CW'(WRITE_LATENCY - 1);
                    state_next = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (!read) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt <= CW'(1)) begin
                    state_next = RD_DRIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RD_DRIVE: begin
                state_next = HOLD;
                kind_next  = HOLD_RD;
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    kind_next  = HOLD_WR;
                end else if (!write) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HOLD: begin
                case (kind)
                    HOLD_RD: if (!read)           state_next = IDLE;
                    HOLD_WR: if (!write)          state_next = IDLE;
                    default: if (!read && !write) state_next = IDLE;
                endcase
            end
            ERR: begin
                state_next = HOLD;
                kind_next  = HOLD_ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only; reset masks the pulses so an aborted transfer never completes.
    always_comb begin
        ready = 1'b0;
        fault = 1'b0;
        drive = 1'b0;
        case (state)
            RD_DRIVE: begin
                ready = !reset;
                drive = 1'b1;
            end
            WR_WAIT:  ready = commit && !reset;
            HOLD:     drive = (kind == HOLD_RD);
            ERR: begin
                ready = !reset;
                fault = !reset;
            end
            default: ;
        endcase
    end

    // Read data is fetched at accept; the serial FSM guarantees no commit can intervene before the drive.
    always_ff @(posedge clock) begin
        if (accept_rd)
            rdata <= mem[addr_idx];
        if (accept_wr) begin
            idx   <= addr_idx;
            wdata <= bus;
        end
        if (commit && !reset)
            mem[idx] <= wdata;
    end

    assign bus = drive ? rdata : 32'bz;

    no_drive_during_write: assert property (@(posedge clock) disable iff (reset) !(drive && write));

endmodule

// File: tb/tb_mem_bus_slave.sv
// Scoreboarded bench for mem_bus_slave: three instances cover the read/write latency corners.
module tb_mem_bus_slave;
    logic        clock;
    logic        reset;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr    [3];
    logic [31:0] cpu_dat [3];
    wire  [31:0] bus0, bus1, bus2;
    wire         rdy0, rdy1, rdy2;
    wire         flt0, flt1, flt2;

    typedef struct {
        int          lat;
        bit          fault;
        bit          is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          viol     = 0;
    logic [31:0] model [16];

    assign bus0 = wr[0] ? cpu_dat[0] : 32'bz;
    assign bus1 = wr[1] ? cpu_dat[1] : 32'bz;
    assign bus2 = wr[2] ? cpu_dat[2] : 32'bz;

    mem_bus_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(2), .WRITE_LATENCY(1)) u0 (
        .clock(clock), .reset(reset), .bus(bus0), .read(rd[0]), .write(wr[0]),
        .address(addr[0]), .ready(rdy0), .fault(flt0));
    mem_bus_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(1), .WRITE_LATENCY(3)) u1 (
        .clock(clock), .reset(reset), .bus(bus1), .read(rd[1]), .write(wr[1]),
        .address(addr[1]), .ready(rdy1), .fault(flt1));
    mem_bus_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(4), .WRITE_LATENCY(3)) u2 (
        .clock(clock), .reset(reset), .bus(bus2), .read(rd[2]), .write(wr[2]),
        .address(addr[2]), .ready(rdy2), .fault(flt2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // The CPU side owns the bus whenever write is high; anything else on it is contention.
    always @(negedge clock) begin
        if (wr[0] && (bus0 !== cpu_dat[0])) viol++;
        if (wr[1] && (bus1 !== cpu_dat[1])) viol++;
        if (wr[2] && (bus2 !== cpu_dat[2])) viol++;
    end

    function automatic logic [31:0] bus_of(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic logic rdy_of(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic flt_of(input int k);
        case (k)
            0:       return flt0;
            1:       return flt1;
            default: return flt2;
        endcase
    endfunction

    function automatic logic released(input int k);
        logic [31:0] v;
        v = bus_of(k);
        return (v === 32'bz) || (v === 32'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input bit exp_f,
                        input logic [31:0] exp_d);
        exp_t e;
        int   lat;
        bit   seen;
        e.lat   = exp_lat;
        e.fault = exp_f;
        e.is_rd = r;
        e.data  = exp_d;
        exp_q.push_back(e);
        rd[k] = r;
        wr[k] = w;
        addr[k] = a;
        cpu_dat[k] = d;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 16) begin
            tick();
            lat++;
            if (rdy_of(k)) seen = 1'b1;
        end
        e = exp_q.pop_front();
        check("ready_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(lat), 32'(e.lat));
            check("fault", 32'(flt_of(k)), 32'(e.fault));
            if (e.is_rd && !e.fault) check("rdata", bus_of(k), e.data);
            if (!w && e.fault) check("fault_bus_released", 32'(released(k)), 32'd1);
            tick();
            check("ready_width", 32'(rdy_of(k)), 32'd0);
            if (e.is_rd && !e.fault) check("rdata_held", bus_of(k), e.data);
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        tick();
        check("bus_released", 32'(released(k)), 32'd1);
    endtask

    task automatic abort(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int n_high);
        int pulses;
        pulses = 0;
        rd[k] = r;
        wr[k] = w;
        addr[k] = a;
        cpu_dat[k] = d;
        repeat (n_high) begin
            tick();
            if (rdy_of(k)) pulses++;
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        repeat (5) begin
            tick();
            if (rdy_of(k)) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);
        check("abort_bus_released", 32'(released(k)), 32'd1);
    endtask

    initial begin
        int          op;
        int          w;
        logic [31:0] a;
        logic [31:0] d;

        reset = 1'b1;
        rd = '0;
        wr = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0;
            cpu_dat[k] = '0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 32'(rdy_of(k)), 32'd0);
            check("reset_fault", 32'(flt_of(k)), 32'd0);
            check("reset_bus", 32'(released(k)), 32'd1);
        end
        reset = 1'b0;
        tick();

        // Reset in RD_WAIT aborts the read; memory survives.
        xfer(0, 0, 1, 32'h10, 32'hA5A5_0004, 1, 0, 0);
        rd[0] = 1'b1;
        addr[0] = 32'h10;
        tick();
        reset = 1'b1;
        tick();
        check("rst_rd_ready", 32'(rdy0), 32'd0);
        check("rst_rd_bus", 32'(released(0)), 32'd1);
        rd[0] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_rd_no_late_ready", 32'(rdy0), 32'd0);
        xfer(0, 1, 0, 32'h10, 32'h0, 2, 0, 32'hA5A5_0004);

        // Reset in the commit cycle: no pulse, no write.
        wr[0] = 1'b1;
        addr[0] = 32'h10;
        cpu_dat[0] = 32'hBADB_AD00;
        tick();
        reset = 1'b1;
        #1;
        check("rst_wr_ready", 32'(rdy0), 32'd0);
        tick();
        wr[0] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        xfer(0, 1, 0, 32'h10, 32'h0, 2, 0, 32'hA5A5_0004);

        // Write then read back, plus last-word boundary.
        xfer(0, 0, 1, 32'h8, 32'hDEAD_BEEF, 1, 0, 0);
        xfer(0, 1, 0, 32'h8, 32'h0, 2, 0, 32'hDEAD_BEEF);
        xfer(0, 0, 1, 32'hFFC, 32'hCAFE_F00D, 1, 0, 0);
        xfer(0, 1, 0, 32'hFFC, 32'h0, 2, 0, 32'hCAFE_F00D);

        // Latency corners.
        xfer(1, 0, 1, 32'h20, 32'h1111_2222, 3, 0, 0);
        xfer(1, 1, 0, 32'h20, 32'h0, 1, 0, 32'h1111_2222);
        xfer(2, 0, 1, 32'h40, 32'h3333_4444, 3, 0, 0);
        xfer(2, 1, 0, 32'h40, 32'h0, 4, 0, 32'h3333_4444);

        // Faults.
        xfer(0, 0, 1, 32'h0, 32'h1111_0000, 1, 0, 0);
        xfer(0, 1, 0, 32'h1000, 32'h0, 1, 1, 0);
        xfer(0, 0, 1, 32'h2, 32'h5555_AAAA, 1, 1, 0);
        xfer(0, 1, 0, 32'h0, 32'h0, 2, 0, 32'h1111_0000);
        xfer(0, 1, 1, 32'h0, 32'h7777_7777, 1, 1, 0);
        xfer(0, 1, 0, 32'h0, 32'h0, 2, 0, 32'h1111_0000);

        // Aborted write and read.
        xfer(1, 0, 1, 32'h4, 32'h4444_0004, 3, 0, 0);
        abort(1, 0, 1, 32'h4, 32'h1234_5678, 1);
        xfer(1, 1, 0, 32'h4, 32'h0, 1, 0, 32'h4444_0004);
        abort(2, 1, 0, 32'h40, 32'h0, 2);
        xfer(2, 1, 0, 32'h40, 32'h0, 4, 0, 32'h3333_4444);

        // Random traffic over a 16-word window against the model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer(0, 0, 1, 32'(i) << 2, model[i], 1, 0, 0);
        end
        for (int t = 0; t < 1200; t++) begin
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 15);
            a  = 32'(w) << 2;
            d  = $urandom;
            repeat ($urandom_range(0, 2)) tick();
            if (op < 5) begin
                xfer(0, 1, 0, a, 32'h0, 2, 0, model[w]);
            end else if (op < 8) begin
                xfer(0, 0, 1, a, d, 1, 0, 0);
                model[w] = d;
            end else begin
                case ($urandom_range(0, 3))
                    0:       xfer(0, 1, 0, 32'h1000 + a, 32'h0, 1, 1, 0);
                    1:       xfer(0, 0, 1, a + 32'($urandom_range(1, 3)), d, 1, 1, 0);
                    2:       xfer(0, 0, 1, 32'h8000_0000 | a, d, 1, 1, 0);
                    default: xfer(0, 1, 1, a, d, 1, 1, 0);
                endcase
            end
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("no_bus_contention", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
